// File: rtl/als_light_monitor_pkg.sv
// Shared constants for the ambient-light monitor: FSM encodings, min/max
// reset values and the hysteresis decision used by the dark flag.
package als_light_monitor_pkg;

    // Fill/run state encodings
    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // min starts at the top of the range and max at the bottom so the first
    // accepted sample replaces both
    localparam logic [7:0] MIN_INIT = 8'hFF;
    localparam logic [7:0] MAX_INIT = 8'h00;

    // Hysteresis: below lo -> dark, above hi -> light, in between -> hold
    function automatic logic hyst_next(input logic        cur,
                                       input logic [7:0]  a,
                                       input int unsigned lo,
                                       input int unsigned hi);
        logic r;
        r = cur;
        if (32'(a) < lo)
            r = 1'b1;
        else if (32'(a) > hi)
            r = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/als_sample_timer.sv
// Free-running sample period counter: counts 0..SAMPLE_PERIOD-1 and wraps,
// stb is high for the whole cycle in which the count is at its last value.
module als_sample_timer
    import als_light_monitor_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic stb
);

    localparam int unsigned CW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

    logic [CW-1:0] r_cnt;

    // Period counter; clear restarts the period from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clear || r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    assign stb = (r_cnt == LAST);

endmodule

// File: rtl/als_light_monitor.sv
// Ambient light statistics: periodic sampling of an 8-bit light level into
// an N-deep window, windowed mean with fill tracking, a hysteresis dark flag
// and running min/max since reset or clear.
module als_light_monitor
    import als_light_monitor_pkg::*;
#(
    parameter int unsigned SAMPLE_PERIOD = 1000,
    parameter int unsigned AVG_LOG2      = 3,
    parameter int unsigned TH_LOW        = 40,
    parameter int unsigned TH_HIGH       = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    input  logic       clear,
    output logic       sample_stb,
    output logic [7:0] avg,
    output logic       avg_valid,
    output logic       dark,
    output logic [7:0] min_val,
    output logic [7:0] max_val
);

    localparam int unsigned N  = 1 << AVG_LOG2;
    localparam int unsigned SW = 8 + AVG_LOG2;
    localparam int unsigned AW = AVG_LOG2;

    logic            w_tmr_stb;
    logic            w_sample;
    logic [7:0]      w_oldest;
    logic [SW-1:0]   w_sum_next;
    logic [7:0]      w_avg_next;

    logic [7:0]      r_buf [N];
    logic [AW-1:0]   r_wptr;
    logic [SW-1:0]   r_sum;
    logic [AW-1:0]   r_fill_cnt;
    logic [0:0]      r_state;
    logic            r_upd;
    logic [7:0]      r_avg;
    logic            r_avg_valid;
    logic            r_dark;
    logic [7:0]      r_min;
    logic [7:0]      r_max;

    als_sample_timer #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .stb   (w_tmr_stb)
    );

    // A sample coinciding with clear is dropped entirely, strobe included
    assign w_sample   = w_tmr_stb & ~clear;
    assign sample_stb = w_sample;

    // The entry under the write pointer is the one about to be overwritten.
    // Intermediate wrap in sum+value-oldest is harmless: the result always
    // fits SW bits because it is the sum of N bytes.
    assign w_oldest   = r_buf[r_wptr];
    assign w_sum_next = r_sum + SW'(value) - SW'(w_oldest);
    assign w_avg_next = r_sum[SW-1:AW];

    // Circular window, write pointer and running sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N); i++) r_buf[i] <= '0;
            r_wptr <= '0;
            r_sum  <= '0;
        end else if (clear) begin
            for (int i = 0; i < int'(N); i++) r_buf[i] <= '0;
            r_wptr <= '0;
            r_sum  <= '0;
        end else if (w_sample) begin
            r_buf[r_wptr] <= value;
            r_wptr        <= r_wptr + AW'(1);
            r_sum         <= w_sum_next;
        end
    end

    // Fill tracking: S_RUN once N real samples are in the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FILL;
            r_fill_cnt <= '0;
        end else if (clear) begin
            r_state    <= S_FILL;
            r_fill_cnt <= '0;
        end else if (w_sample && r_state == S_FILL) begin
            if (r_fill_cnt == AW'(N - 1))
                r_state <= S_RUN;
            else
                r_fill_cnt <= r_fill_cnt + AW'(1);
        end
    end

    // One-cycle marker that the sum just changed; avg follows on the next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_upd <= 1'b0;
        else if (clear)
            r_upd <= 1'b0;
        else
            r_upd <= w_sample;
    end

    // Registered mean, validity and dark flag, all moving on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_dark      <= 1'b0;
        end else if (clear) begin
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_dark      <= 1'b0;
        end else if (r_upd) begin
            r_avg <= w_avg_next;
            if (r_state == S_RUN) begin
                r_avg_valid <= 1'b1;
                r_dark      <= hyst_next(r_dark, w_avg_next, TH_LOW, TH_HIGH);
            end
        end
    end

    // Extremes of raw samples since reset or clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min <= MIN_INIT;
            r_max <= MAX_INIT;
        end else if (clear) begin
            r_min <= MIN_INIT;
            r_max <= MAX_INIT;
        end else if (w_sample) begin
            if (value < r_min) r_min <= value;
            if (value > r_max) r_max <= value;
        end
    end

    assign avg       = r_avg;
    assign avg_valid = r_avg_valid;
    assign dark      = r_dark;
    assign min_val   = r_min;
    assign max_val   = r_max;

endmodule

// File: tb/tb_als_light_monitor.sv
// Scoreboard bench for als_light_monitor: the stimulus side feeds samples to
// a window-level reference model and queues the expected outputs; a monitor
// watches sample_stb and compares two cycles later.
module tb_als_light_monitor;

    localparam int SP = 4;
    localparam int LG = 3;
    localparam int NW = 1 << LG;
    localparam int TL = 40;
    localparam int TH = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] value = 8'd100;
    logic       clear = 1'b0;
    logic       sample_stb;
    logic [7:0] avg;
    logic       avg_valid;
    logic       dark;
    logic [7:0] min_val;
    logic [7:0] max_val;

    als_light_monitor #(
        .SAMPLE_PERIOD (SP),
        .AVG_LOG2      (LG),
        .TH_LOW        (TL),
        .TH_HIGH       (TH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .clear      (clear),
        .sample_stb (sample_stb),
        .avg        (avg),
        .avg_valid  (avg_valid),
        .dark       (dark),
        .min_val    (min_val),
        .max_val    (max_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        int avg;
        int valid;
        int dark;
        int mn;
        int mx;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: the last N accepted samples, zero-padded while filling
    int m_hist[$];
    int m_n;
    int m_min, m_max, m_dark;

    task automatic m_reset();
        m_hist.delete();
        m_n = 0; m_min = 255; m_max = 0; m_dark = 0;
    endtask

    task automatic accept(input int v);
        int s;
        exp_t e;
        m_hist.push_back(v);
        if (m_hist.size() > NW) void'(m_hist.pop_front());
        m_n++;
        s = 0;
        foreach (m_hist[i]) s += m_hist[i];
        e.avg   = s / NW;
        e.valid = (m_n >= NW) ? 1 : 0;
        if (e.valid == 1) begin
            if (e.avg < TL) m_dark = 1;
            else if (e.avg > TH) m_dark = 0;
        end
        if (v < m_min) m_min = v;
        if (v > m_max) m_max = v;
        e.dark = m_dark; e.mn = m_min; e.mx = m_max;
        q.push_back(e);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_avg"},   int'(avg), 0);
        chk({tag, "_valid"}, int'(avg_valid), 0);
        chk({tag, "_dark"},  int'(dark), 0);
        chk({tag, "_min"},   int'(min_val), 255);
        chk({tag, "_max"},   int'(max_val), 0);
    endtask

    // Monitor: one cycle after a strobe avg must not have moved yet, two
    // cycles after it must match the queued expectation
    int mon_d    = 0;
    int last_avg = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            mon_d = 0; last_avg = 0;
        end else begin
            if (mon_d == 1) begin
                mon_d = 0;
                if (q.size() == 0) begin
                    chk("queue_empty_on_update", 0, 1);
                end else begin
                    e = q.pop_front();
                    chk("avg",       int'(avg),       e.avg);
                    chk("avg_valid", int'(avg_valid), e.valid);
                    chk("dark",      int'(dark),      e.dark);
                    chk("min_val",   int'(min_val),   e.mn);
                    chk("max_val",   int'(max_val),   e.mx);
                    last_avg = e.avg;
                end
            end else if (mon_d == 2) begin
                chk("avg_latency_hold", int'(avg), last_avg);
                mon_d = 1;
            end
            if (clear) last_avg = 0;
            if (sample_stb) mon_d = 2;
        end
    end

    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (sample_stb) begin ok = 1'b1; break; end
        end
    endtask

    // Present v for the next sample, then scramble value between samples
    task automatic do_sample(input int v);
        bit ok;
        @(posedge clk); #1 value = 8'(v);
        wait_stb(ok);
        if (!ok) chk("stb_timeout", 0, 1);
        else accept(v);
        @(posedge clk); #1 value = 8'($urandom);
    endtask

    // Clear two cycles after a sample (not coincident with a strobe)
    task automatic do_clear();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        m_reset();
        chk_idle("clear");
    endtask

    // Clear landing exactly on the next strobe cycle (call right after do_sample)
    task automatic do_clear_on_stb();
        repeat (3) @(posedge clk);
        #1 clear = 1'b1; value = 8'd3;
        @(negedge clk);
        chk("stb_masked_by_clear", int'(sample_stb), 0);
        @(posedge clk); #1 clear = 1'b0;
        m_reset();
        chk_idle("clear_coinc");
    endtask

    // Asynchronous reset pulse, then measure latency to the first strobe
    task automatic do_reset(input int v);
        int k;
        bit found;
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        chk("rst_stb", int'(sample_stb), 0);
        chk_idle("rst");
        m_reset();
        q.delete();
        value = 8'(v);
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        found = 1'b0; k = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (sample_stb) begin k = i; found = 1'b1; break; end
        end
        chk("first_stb_edges_after_release", k, SP - 1);
        if (found) accept(v);
        @(posedge clk); #1 value = 8'($urandom);
    endtask

    initial begin
        m_reset();
        #2;
        // Power-on reset; first sample of the constant-100 run
        do_reset(100);
        for (int i = 0; i < 11; i++) do_sample(100);
        do_clear();

        // Extremes alternating: sum 1020 -> avg 127
        for (int i = 0; i < 10; i++) do_sample((i % 2 == 0) ? 0 : 255);
        do_clear();

        // Hysteresis walk
        for (int i = 0; i < 8; i++)  do_sample(100);
        for (int i = 0; i < 10; i++) do_sample(20);
        chk("dark_after_low", m_dark, 1);
        for (int i = 0; i < 8; i++)  do_sample(50);
        for (int i = 0; i < 10; i++) do_sample(70);
        chk("light_after_high", m_dark, 0);
        do_clear();

        // Clear mid-fill, then a clear that swallows a strobe
        for (int i = 0; i < 5; i++) do_sample(int'($urandom_range(0, 255)));
        do_clear();
        for (int i = 0; i < 3; i++) do_sample(int'($urandom_range(10, 200)));
        do_clear_on_stb();
        for (int i = 0; i < 10; i++) do_sample(int'($urandom_range(0, 255)));

        // Random run around the thresholds
        for (int i = 0; i < 24; i++) do_sample(int'($urandom_range(0, 110)));

        // Asynchronous reset mid-run, then refill
        do_reset(int'($urandom_range(0, 255)));
        for (int i = 0; i < 9; i++) do_sample(int'($urandom_range(0, 255)));

        repeat (4) @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
